bsg_cache_sbuf_drain: RTL and testbench
=======================================

# bsg_cache_sbuf_drain

Drain side of the cache store buffer. Pops entries from the 2-element store-buffer queue with a valid/yumi handshake, holds one entry, and issues a masked write to the data array through a valid/ready port. Loads own the data array (`stall_i`), and a saturating starvation counter forces a drain after a configurable number of blocked cycles. The block sits between the store-buffer queue output and the data-array write mux in the cache pipeline.

## Interface
Parameters:
- `addr_width_p`, 28, word address width.
- `data_width_p`, 32, data width; must be a multiple of 8.
- `starve_limit_p`, 8, blocked cycles before a forced drain; range 1..255.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `v_i`  in  1  queue entry valid.
- `entry_i`  in  `$bits(bsg_cache_sbuf_entry_s)`  entry, packed as {mask, data, addr}.
- `yumi_o`  out  1  entry consumed this cycle.
- `stall_i`  in  1  load pipeline owns the data array this cycle.
- `mem_v_o`  out  1  write request valid.
- `mem_addr_o`  out  `addr_width_p`  write word address.
- `mem_data_o`  out  `data_width_p`  write data.
- `mem_mask_o`  out  `data_width_p/8`  byte write enables.
- `mem_ready_i`  in  1  data array accepts the write.
- `starve_o`  out  1  forced-drain indication to the array arbiter.
- `empty_o`  out  1  no entry held.

## Operation
- State is `hold_v_r` plus the hold register (addr, data, mask) plus the starve counter.
- Two FSM states:
  - EMPTY (`hold_v_r`=0).
  - HELD (`hold_v_r`=1).
- Retire condition: `retire = mem_v_o & mem_ready_i`.
- Request valid: `mem_v_o = hold_v_r & (~stall_i | starve_o)`. A starved entry overrides `stall_i`.
- Accept condition: `yumi_o = v_i & ~reset_i & (~hold_v_r | retire)`. An accepted entry loads the hold register.
- Transitions:
  - EMPTY -> HELD on `yumi_o`.
  - HELD -> EMPTY on `retire & ~yumi_o`.
  - HELD -> HELD on `retire & yumi_o` (back-to-back drain), or when there is no retire.
- `mem_addr_o`, `mem_data_o` and `mem_mask_o` are driven directly from the hold register. They are stable while `mem_v_o`=1 and `mem_ready_i`=0.
- Starve counter, width `$clog2(starve_limit_p+1)`:
  - Clears on retire or when EMPTY.
  - Otherwise increments each HELD cycle without retire, saturating at `starve_limit_p`.
- `starve_o` = (counter == `starve_limit_p`).
- `empty_o` = ~`hold_v_r`.
- An entry with an all-zero mask is still written (no filtering).

## Timing
- Reset values: `hold_v_r`=0, counter=0, hold register=0. Outputs during reset: `yumi_o`=0, `mem_v_o`=0, `starve_o`=0, `empty_o`=1.
- Reset may assert mid-request. The held entry is discarded; the upstream queue is reset by the same signal.
- Latency: an entry accepted in cycle N gives `mem_v_o`=1 in cycle N+1 at the earliest.
- Sustained throughput is 1 write/cycle (accept and retire in the same cycle).
- `yumi_o` depends combinationally on `v_i`, `stall_i` and `mem_ready_i`. No path exists from `yumi_o` back to `v_i`.
- `stall_i` held continuously with an entry held: `starve_o` rises after exactly `starve_limit_p` HELD cycles, and `mem_v_o` asserts in that same cycle.

## Configuration
- Macro: `BSG_CACHE_SBUF_DRAIN_MERGE_EN`.
- Defined: merge applies when HELD, `mem_v_o`=0 (stalled), `v_i`=1 and `entry_i.addr` == hold addr.
  - `yumi_o`=1.
  - Bytes enabled in `entry_i.mask` overwrite hold data.
  - Hold mask becomes (hold mask | `entry_i.mask`).
  - The starve counter is not cleared by a merge.
- Defined, no-merge cases: no merge while `mem_v_o`=1, since request fields must stay stable.
- Undefined: no merging; `yumi_o` follows the base equation only.

## Structure
- Package `bsg_cache_sbuf_pkg` holds:
  - `bsg_cache_sbuf_entry_s` (mask, data, addr), parameterized through localparams of the same widths as the parameters.
  - The `bsg_cache_sbuf_drain_state_e` enum (EMPTY, HELD).
- One sub-module: `bsg_cache_sbuf_starve_ctr`, a saturating counter with clear, increment, limit and `at_limit` output.

## Test plan
- Single entry, addr 0x10, data 0xDEADBEEF, mask 0xF, `stall_i`=0, `mem_ready_i`=1 -> `yumi_o` in cycle 0; `mem_v_o` with those fields in cycle 1; `empty_o`=1 in cycle 2.
- Four entries back-to-back with `mem_ready_i`=1 and no stall -> four consecutive accepts and four consecutive writes, in order, at 1/cycle.
- Entry held with `stall_i`=1 for 20 cycles, `starve_limit_p`=8 -> `mem_v_o`=0 for 8 cycles; `starve_o`=1 and `mem_v_o`=1 in the 9th HELD cycle; both clear after retire.
- `mem_ready_i`=0 for 5 cycles with `mem_v_o`=1 -> fields unchanged every cycle; `yumi_o`=0 throughout despite `v_i`=1.
- Merge enabled, stalled hold addr 0x20 mask 0x3 data 0x0000AAAA, new entry addr 0x20 mask 0xC data 0xBBBB0000 -> `yumi_o`=1; the eventual write has mask 0xF and data 0xBBBBAAAA. With merge disabled, two separate writes.
- Reset asserted while `mem_v_o`=1 -> `mem_v_o`=0 and `empty_o`=1 immediately; no write after deassertion.

Source files
------------

// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared types for the store-buffer drain: entry layout {mask, data, addr} and drain FSM states.
package bsg_cache_sbuf_pkg;

    localparam int addr_width_lp = 28;
    localparam int data_width_lp = 32;
    localparam int mask_width_lp = data_width_lp / 8;

    typedef struct packed {
        logic [mask_width_lp-1:0] mask;
        logic [data_width_lp-1:0] data;
        logic [addr_width_lp-1:0] addr;
    } bsg_cache_sbuf_entry_s;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } bsg_cache_sbuf_drain_state_e;

endpackage

// File: rtl/bsg_cache_sbuf_starve_ctr.sv
// Saturating starvation counter: clear has priority, increments stop at limit_p.
module bsg_cache_sbuf_starve_ctr
    import bsg_cache_sbuf_pkg::*;
#(
    parameter int limit_p = 8,
    parameter int width_p = $clog2(limit_p + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic incr_i,
    output logic at_limit_o
);

    localparam logic [width_p-1:0] limit_lp = width_p'(limit_p);

    logic [width_p-1:0] count_r;

    // counter state with clear-over-increment priority and saturation
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= {width_p{1'b0}};
        end else if (clear_i) begin
            count_r <= {width_p{1'b0}};
        end else if (incr_i && (count_r != limit_lp)) begin
            count_r <= count_r + {{(width_p-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign at_limit_o = (count_r == limit_lp);

endmodule

// File: rtl/bsg_cache_sbuf_drain.sv
// Store-buffer drain: holds one entry and writes it to the data array; loads may stall it until starved.
// Optional same-address merging while stalled is enabled by defining BSG_CACHE_SBUF_DRAIN_MERGE_EN.
module bsg_cache_sbuf_drain
    import bsg_cache_sbuf_pkg::*;
#(
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int starve_limit_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    input  bsg_cache_sbuf_entry_s       entry_i,
    output logic                        yumi_o,
    input  logic                        stall_i,
    output logic                        mem_v_o,
    output logic [addr_width_p-1:0]     mem_addr_o,
    output logic [data_width_p-1:0]     mem_data_o,
    output logic [data_width_p/8-1:0]   mem_mask_o,
    input  logic                        mem_ready_i,
    output logic                        starve_o,
    output logic                        empty_o
);

    localparam int mask_width_lp_l = data_width_p / 8;

    function automatic logic [data_width_p-1:0] merge_bytes(
        input logic [data_width_p-1:0]    old_data,
        input logic [data_width_p-1:0]    new_data,
        input logic [mask_width_lp_l-1:0] new_mask
    );
        logic [data_width_p-1:0] result;
        result = old_data;
        for (int b = 0; b < mask_width_lp_l; b++) begin
            if (new_mask[b]) begin
                result[8*b +: 8] = new_data[8*b +: 8];
            end else begin
                result[8*b +: 8] = old_data[8*b +: 8];
            end
        end
        return result;
    endfunction

    bsg_cache_sbuf_drain_state_e state_r;
    logic [addr_width_p-1:0]     hold_addr_r;
    logic [data_width_p-1:0]     hold_data_r;
    logic [mask_width_lp_l-1:0]  hold_mask_r;

    logic [addr_width_p-1:0]     hold_addr_n;
    logic [data_width_p-1:0]     hold_data_n;
    logic [mask_width_lp_l-1:0]  hold_mask_n;

    logic [addr_width_p-1:0]     entry_addr_s;
    logic [data_width_p-1:0]     entry_data_s;
    logic [mask_width_lp_l-1:0]  entry_mask_s;

    logic hold_v_r;
    logic retire_s;
    logic merge_s;

    assign entry_addr_s = addr_width_p'(entry_i.addr);
    assign entry_data_s = data_width_p'(entry_i.data);
    assign entry_mask_s = mask_width_lp_l'(entry_i.mask);

    assign hold_v_r = (state_r == HELD);
    // a starved entry wins the array even when loads want it
    assign mem_v_o  = hold_v_r & (~stall_i | starve_o);
    assign retire_s = mem_v_o & mem_ready_i;

`ifdef BSG_CACHE_SBUF_DRAIN_MERGE_EN
    // only merge while the request is not presented, so its fields never move under the array
    assign merge_s = hold_v_r & ~mem_v_o & v_i & (entry_addr_s == hold_addr_r);
`else
    assign merge_s = 1'b0;
`endif

    assign yumi_o  = v_i & ~reset_i & (~hold_v_r | retire_s | merge_s);
    assign empty_o = ~hold_v_r;

    assign mem_addr_o = hold_addr_r;
    assign mem_data_o = hold_data_r;
    assign mem_mask_o = hold_mask_r;

    // next hold-register contents: merge, fresh load, or keep
    always_comb begin
        hold_addr_n = hold_addr_r;
        hold_data_n = hold_data_r;
        hold_mask_n = hold_mask_r;
        if (merge_s) begin
            hold_data_n = merge_bytes(hold_data_r, entry_data_s, entry_mask_s);
            hold_mask_n = hold_mask_r | entry_mask_s;
        end else if (yumi_o) begin
            hold_addr_n = entry_addr_s;
            hold_data_n = entry_data_s;
            hold_mask_n = entry_mask_s;
        end else begin
            hold_addr_n = hold_addr_r;
            hold_data_n = hold_data_r;
            hold_mask_n = hold_mask_r;
        end
    end

    // drain FSM and hold register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= EMPTY;
            hold_addr_r <= {addr_width_p{1'b0}};
            hold_data_r <= {data_width_p{1'b0}};
            hold_mask_r <= {mask_width_lp_l{1'b0}};
        end else begin
            case (state_r)
                EMPTY:   state_r <= yumi_o ? HELD : EMPTY;
                HELD:    state_r <= (retire_s & ~yumi_o) ? EMPTY : HELD;
                default: state_r <= EMPTY;
            endcase
            hold_addr_r <= hold_addr_n;
            hold_data_r <= hold_data_n;
            hold_mask_r <= hold_mask_n;
        end
    end

    bsg_cache_sbuf_starve_ctr #(
        .limit_p (starve_limit_p)
    ) starve_ctr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (retire_s | ~hold_v_r),
        .incr_i     (hold_v_r & ~retire_s),
        .at_limit_o (starve_o)
    );

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Bench for bsg_cache_sbuf_drain: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_bsg_cache_sbuf_drain;
    import bsg_cache_sbuf_pkg::*;

    localparam int LIMIT = 8;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic                  v_i;
    bsg_cache_sbuf_entry_s entry_i;
    logic                  yumi_o;
    logic                  stall_i;
    logic                  mem_v_o;
    logic [27:0]           mem_addr_o;
    logic [31:0]           mem_data_o;
    logic [3:0]            mem_mask_o;
    logic                  mem_ready_i;
    logic                  starve_o;
    logic                  empty_o;

    int checks = 0;
    int errors = 0;

    bsg_cache_sbuf_drain #(
        .addr_width_p   (28),
        .data_width_p   (32),
        .starve_limit_p (LIMIT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .entry_i     (entry_i),
        .yumi_o      (yumi_o),
        .stall_i     (stall_i),
        .mem_v_o     (mem_v_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_mask_o  (mem_mask_o),
        .mem_ready_i (mem_ready_i),
        .starve_o    (starve_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    function automatic bsg_cache_sbuf_entry_s mk(input logic [27:0] a, input logic [31:0] d, input logic [3:0] m);
        bsg_cache_sbuf_entry_s e;
        e.mask = m;
        e.data = d;
        e.addr = a;
        return e;
    endfunction

    function automatic bsg_cache_sbuf_entry_s rnd_entry();
        return mk(28'($urandom), 32'($urandom), 4'($urandom));
    endfunction

    // apply inputs just after a rising edge, return at the following falling edge for sampling
    task automatic drive(input logic v, input bsg_cache_sbuf_entry_s e, input logic st, input logic rdy);
        @(posedge clk);
        #1;
        v_i = v;
        entry_i = e;
        stall_i = st;
        mem_ready_i = rdy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        v_i = 1'b1;
        entry_i = mk(28'h1, 32'h1, 4'h1);
        stall_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        checks++;
        if ({yumi_o, mem_v_o, starve_o, empty_o} !== 4'b0001)
            $display("FAIL reset_outputs got %b want 0001", {yumi_o, mem_v_o, starve_o, empty_o});
        if ({yumi_o, mem_v_o, starve_o, empty_o} !== 4'b0001) errors++;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_v_o, starve_o, empty_o} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release got %b want 001", {mem_v_o, starve_o, empty_o});
        end
    endtask

    task automatic test_single();
        bsg_cache_sbuf_entry_s e;
        e = mk(28'h10, 32'hDEADBEEF, 4'hF);
        drive(1'b1, e, 1'b0, 1'b1);
        checks++;
        if ({yumi_o, mem_v_o, empty_o} !== 3'b101) begin
            errors++;
            $display("FAIL single_c0 got %b want 101", {yumi_o, mem_v_o, empty_o});
        end
        drive(1'b0, e, 1'b0, 1'b1);
        checks++;
        if ({yumi_o, mem_v_o, empty_o, mem_addr_o, mem_data_o, mem_mask_o} !== {3'b010, e.addr, e.data, e.mask}) begin
            errors++;
            $display("FAIL single_c1 got %b %h %h %h want 010 %h %h %h", {yumi_o, mem_v_o, empty_o},
                     mem_addr_o, mem_data_o, mem_mask_o, e.addr, e.data, e.mask);
        end
        drive(1'b0, e, 1'b0, 1'b1);
        checks++;
        if ({mem_v_o, empty_o} !== 2'b01) begin
            errors++;
            $display("FAIL single_c2 got %b want 01", {mem_v_o, empty_o});
        end
    endtask

    task automatic test_back_to_back();
        bsg_cache_sbuf_entry_s es [4];
        for (int i = 0; i < 4; i++) es[i] = rnd_entry();
        for (int i = 0; i <= 4; i++) begin
            drive(i < 4, es[(i < 4) ? i : 3], 1'b0, 1'b1);
            checks++;
            if ({yumi_o, mem_v_o} !== {(i < 4) ? 1'b1 : 1'b0, (i > 0) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL b2b_hs%0d got %b", i, {yumi_o, mem_v_o});
            end
            if (i > 0) begin
                checks++;
                if ({mem_addr_o, mem_data_o, mem_mask_o} !== {es[i-1].addr, es[i-1].data, es[i-1].mask}) begin
                    errors++;
                    $display("FAIL b2b_fields%0d got %h %h %h want %h %h %h", i, mem_addr_o, mem_data_o,
                             mem_mask_o, es[i-1].addr, es[i-1].data, es[i-1].mask);
                end
            end
        end
    endtask

    task automatic test_starve();
        bsg_cache_sbuf_entry_s e;
        e = rnd_entry();
        drive(1'b1, e, 1'b1, 1'b1);
        checks++;
        if (yumi_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_accept got %b want 1", yumi_o);
        end
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, e, 1'b1, 1'b1);
            checks++;
            if ({mem_v_o, starve_o, empty_o} !== {k == 9, k == 9, k > 9}) begin
                errors++;
                $display("FAIL starve_k%0d got %b want %b", k, {mem_v_o, starve_o, empty_o}, {k == 9, k == 9, k > 9});
            end
        end
    endtask

    task automatic test_ready_low();
        bsg_cache_sbuf_entry_s a;
        bsg_cache_sbuf_entry_s b;
        a = rnd_entry();
        b = rnd_entry();
        drive(1'b1, a, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, b, 1'b0, 1'b0);
            checks++;
            if ({yumi_o, mem_v_o, mem_addr_o, mem_data_o, mem_mask_o} !== {2'b01, a.addr, a.data, a.mask}) begin
                errors++;
                $display("FAIL ready_low%0d got %b %h %h %h want 01 %h %h %h", k, {yumi_o, mem_v_o},
                         mem_addr_o, mem_data_o, mem_mask_o, a.addr, a.data, a.mask);
            end
        end
        drive(1'b1, b, 1'b0, 1'b1);
        checks++;
        if ({yumi_o, mem_v_o, mem_addr_o} !== {2'b11, a.addr}) begin
            errors++;
            $display("FAIL ready_release got %b %h want 11 %h", {yumi_o, mem_v_o}, mem_addr_o, a.addr);
        end
        drive(1'b0, b, 1'b0, 1'b1);
        checks++;
        if ({mem_v_o, mem_addr_o, mem_data_o, mem_mask_o} !== {1'b1, b.addr, b.data, b.mask}) begin
            errors++;
            $display("FAIL ready_next got %b %h %h %h want 1 %h %h %h", mem_v_o, mem_addr_o, mem_data_o,
                     mem_mask_o, b.addr, b.data, b.mask);
        end
        drive(1'b0, b, 1'b0, 1'b1);
    endtask

    task automatic test_merge();
        bsg_cache_sbuf_entry_s a;
        bsg_cache_sbuf_entry_s b;
        a = mk(28'h20, 32'h0000AAAA, 4'h3);
        b = mk(28'h20, 32'hBBBB0000, 4'hC);
        drive(1'b1, a, 1'b1, 1'b1);
        drive(1'b1, b, 1'b1, 1'b1);
`ifdef BSG_CACHE_SBUF_DRAIN_MERGE_EN
        checks++;
        if ({yumi_o, mem_v_o} !== 2'b10) begin
            errors++;
            $display("FAIL merge_accept got %b want 10", {yumi_o, mem_v_o});
        end
        drive(1'b0, b, 1'b0, 1'b1);
        checks++;
        if ({mem_v_o, mem_addr_o, mem_data_o, mem_mask_o} !== {1'b1, 28'h20, 32'hBBBBAAAA, 4'hF}) begin
            errors++;
            $display("FAIL merge_write got %b %h %h %h want 1 20 bbbbaaaa f", mem_v_o, mem_addr_o, mem_data_o, mem_mask_o);
        end
`else
        checks++;
        if ({yumi_o, mem_v_o} !== 2'b00) begin
            errors++;
            $display("FAIL nomerge_hold got %b want 00", {yumi_o, mem_v_o});
        end
        drive(1'b1, b, 1'b0, 1'b1);
        checks++;
        if ({yumi_o, mem_v_o, mem_data_o, mem_mask_o} !== {2'b11, a.data, a.mask}) begin
            errors++;
            $display("FAIL nomerge_w1 got %b %h %h want 11 %h %h", {yumi_o, mem_v_o}, mem_data_o, mem_mask_o, a.data, a.mask);
        end
        drive(1'b0, b, 1'b0, 1'b1);
        checks++;
        if ({mem_v_o, mem_data_o, mem_mask_o} !== {1'b1, b.data, b.mask}) begin
            errors++;
            $display("FAIL nomerge_w2 got %b %h %h want 1 %h %h", mem_v_o, mem_data_o, mem_mask_o, b.data, b.mask);
        end
`endif
        drive(1'b0, b, 1'b0, 1'b1);
        checks++;
        if ({mem_v_o, empty_o} !== 2'b01) begin
            errors++;
            $display("FAIL merge_empty got %b want 01", {mem_v_o, empty_o});
        end
    endtask

    task automatic test_reset_mid();
        bsg_cache_sbuf_entry_s a;
        a = rnd_entry();
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, a, 1'b0, 1'b0);
        #1;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({yumi_o, mem_v_o, starve_o, empty_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid got %b want 0001", {yumi_o, mem_v_o, starve_o, empty_o});
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, a, 1'b0, 1'b1);
            checks++;
            if ({mem_v_o, empty_o} !== 2'b01) begin
                errors++;
                $display("FAIL reset_after%0d got %b want 01", k, {mem_v_o, empty_o});
            end
        end
    endtask

    // reference model: one held entry plus a count of consecutive blocked cycles
    task automatic test_random();
        bit                    held = 1'b0;
        bsg_cache_sbuf_entry_s h = '0;
        int                    blocked = 0;
        bsg_cache_sbuf_entry_s e;
        bit v, st, rdy, exp_starve, exp_mv, retire, merge, exp_yumi;
        int stall_pct;
        for (int n = 0; n < 400; n++) begin
            stall_pct = ((n / 50) % 2 == 1) ? 95 : 30;
            e = rnd_entry();
            if ($urandom_range(0, 1) == 0) e.addr = 28'h20 + 28'($urandom_range(0, 1));
            v   = ($urandom_range(0, 99) < 60);
            st  = ($urandom_range(0, 99) < stall_pct);
            rdy = ($urandom_range(0, 99) < 70);
            drive(v, e, st, rdy);

            exp_starve = held && (blocked >= LIMIT);
            exp_mv     = held && (!st || exp_starve);
            retire     = exp_mv && rdy;
`ifdef BSG_CACHE_SBUF_DRAIN_MERGE_EN
            merge = held && !exp_mv && v && (e.addr == h.addr);
`else
            merge = 1'b0;
`endif
            exp_yumi = v && (!held || retire || merge);

            checks++;
            if ({yumi_o, mem_v_o, starve_o, empty_o} !== {exp_yumi, exp_mv, exp_starve, !held}) begin
                errors++;
                $display("FAIL rand_hs%0d got %b want %b", n, {yumi_o, mem_v_o, starve_o, empty_o},
                         {exp_yumi, exp_mv, exp_starve, !held});
            end
            if (exp_mv) begin
                checks++;
                if ({mem_addr_o, mem_data_o, mem_mask_o} !== {h.addr, h.data, h.mask}) begin
                    errors++;
                    $display("FAIL rand_fields%0d got %h %h %h want %h %h %h", n, mem_addr_o, mem_data_o,
                             mem_mask_o, h.addr, h.data, h.mask);
                end
            end

            blocked = (!held || retire) ? 0 : blocked + 1;
            if (merge) begin
                for (int b = 0; b < 4; b++)
                    if (e.mask[b]) h.data[8*b +: 8] = e.data[8*b +: 8];
                h.mask = h.mask | e.mask;
            end else if (exp_yumi) begin
                h = e;
                held = 1'b1;
            end else if (retire) begin
                held = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_starve();
        test_ready_low();
        test_merge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
